// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: bypass-select encoding,
// stage tag bundles and the forwarding priority rule.
package hazard_pkg;

    localparam int REG_BITS_DEFAULT = 4;

    typedef enum logic [1:0] {
        FWD_RD  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef struct packed {
        logic [REG_BITS_DEFAULT-1:0] ra1;
        logic [REG_BITS_DEFAULT-1:0] ra2;
        logic [REG_BITS_DEFAULT-1:0] wa3;
        logic                        reg_write;
        logic                        mem_to_reg;
    } e_tag_t;

    typedef struct packed {
        logic [REG_BITS_DEFAULT-1:0] wa3;
        logic                        reg_write;
    } mw_tag_t;

    // M is the younger producer, so it shadows a matching write in W.
    function automatic fwd_sel_t fwd_select(input mw_tag_t m, input mw_tag_t w,
                                            input logic [REG_BITS_DEFAULT-1:0] src);
        fwd_sel_t sel;
        sel = FWD_RD;
        if (m.reg_write && (m.wa3 == src)) begin
            sel = FWD_MEM;
        end else if (w.reg_write && (w.wa3 == src)) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Decode-stage register tags in, bypass selects and stall/flush controls out.
// No handshake: every signal is sampled/valid each cycle; outputs are level controls.
interface hazard_unit_if
    import hazard_pkg::*;
#(
    parameter int REG_BITS = REG_BITS_DEFAULT
);

    logic [REG_BITS-1:0] ra1D;
    logic [REG_BITS-1:0] ra2D;
    logic [REG_BITS-1:0] wa3D;
    logic                RegWriteD;
    logic                MemtoRegD;
    logic                PCSrcE;
    logic [1:0]          ForwardAE;
    logic [1:0]          ForwardBE;
    logic                StallF;
    logic                StallD;
    logic                FlushD;
    logic                FlushE;

    modport master (
        output ra1D, ra2D, wa3D, RegWriteD, MemtoRegD, PCSrcE,
        input  ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE
    );

    modport slave (
        input  ra1D, ra2D, wa3D, RegWriteD, MemtoRegD, PCSrcE,
        output ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE
    );

endinterface

// File: rtl/hazard_tag_pipe.sv
// Shadow E/M/W register-tag pipeline; never stalls, E is zeroed on flush.
module hazard_tag_pipe
    import hazard_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    flush_e_i,
    input  e_tag_t  d_tag_i,
    output e_tag_t  e_tag_o,
    output mw_tag_t m_tag_o,
    output mw_tag_t w_tag_o
);

    e_tag_t  e_tag_q, e_tag_d;
    mw_tag_t m_tag_q, m_tag_d;
    mw_tag_t w_tag_q, w_tag_d;

    always_comb begin
        e_tag_d = flush_e_i ? '0 : d_tag_i;
        m_tag_d = '{wa3: e_tag_q.wa3, reg_write: e_tag_q.reg_write};
        w_tag_d = m_tag_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_tag_q <= '0;
            m_tag_q <= '0;
            w_tag_q <= '0;
        end else begin
            e_tag_q <= e_tag_d;
            m_tag_q <= m_tag_d;
            w_tag_q <= w_tag_d;
        end
    end

    assign e_tag_o = e_tag_q;
    assign m_tag_o = m_tag_q;
    assign w_tag_o = w_tag_q;

endmodule

// File: rtl/hazard_unit.sv
// Hazard controller: operand bypass selects, load-use stall and branch flush.
// Define HAZARD_PERF_EN to add saturating stall/flush event counters.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int REG_BITS = REG_BITS_DEFAULT
`ifdef HAZARD_PERF_EN
    ,
    parameter int CNT_BITS = 16
`endif
) (
    input  logic                clk,
    input  logic                rst,
    hazard_unit_if.slave        hz
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_BITS-1:0] stall_cnt,
    output logic [CNT_BITS-1:0] flush_cnt
`endif
);

    logic [REG_BITS-1:0] ra1_d, ra2_d, wa3_d;
    e_tag_t              d_tag, e_tag;
    mw_tag_t             m_tag, w_tag;
    logic                ld_stall;
    logic                flush_e;

    assign ra1_d = hz.ra1D;
    assign ra2_d = hz.ra2D;
    assign wa3_d = hz.wa3D;

    always_comb begin
        d_tag            = '0;
        d_tag.ra1        = ra1_d;
        d_tag.ra2        = ra2_d;
        d_tag.wa3        = wa3_d;
        d_tag.reg_write  = hz.RegWriteD;
        d_tag.mem_to_reg = hz.MemtoRegD;
    end

    hazard_tag_pipe u_tag_pipe (
        .clk       (clk),
        .rst       (rst),
        .flush_e_i (flush_e),
        .d_tag_i   (d_tag),
        .e_tag_o   (e_tag),
        .m_tag_o   (m_tag),
        .w_tag_o   (w_tag)
    );

    // A taken branch squashes the stalled pair, so it overrides the stall.
    always_comb begin
        ld_stall     = e_tag.mem_to_reg && e_tag.reg_write &&
                       ((e_tag.wa3 == ra1_d) || (e_tag.wa3 == ra2_d));
        flush_e      = ld_stall || hz.PCSrcE;
        hz.StallF    = ld_stall && !hz.PCSrcE;
        hz.StallD    = ld_stall && !hz.PCSrcE;
        hz.FlushD    = hz.PCSrcE;
        hz.FlushE    = flush_e;
        hz.ForwardAE = fwd_select(m_tag, w_tag, e_tag.ra1);
        hz.ForwardBE = fwd_select(m_tag, w_tag, e_tag.ra2);
    end

`ifdef HAZARD_PERF_EN
    logic [CNT_BITS-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_BITS-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (hz.StallD && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (hz.PCSrcE && !(&flush_cnt_q)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule
